// File: rtl/nios2_system_v0_cpu_cpu_debug_ocimem_arb.sv
`default_nettype none
// ============================================================================
// Module  : nios2_system_v0_cpu_cpu_debug_ocimem_arb
// Brief   : Arbiter sharing one 256x32 debug RAM between JTAG debug commands
//           (one pending at a time) and the CPU Avalon slave port.
// Rev     : 1.0  initial release
// ============================================================================
module nios2_system_v0_cpu_cpu_debug_ocimem_arb #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              cmd_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_J_RD      = 3'd1;
    localparam logic [2:0] c_J_RD_DATA = 3'd2;
    localparam logic [2:0] c_J_WR      = 3'd3;
    localparam logic [2:0] c_C_RD      = 3'd4;
    localparam logic [2:0] c_C_RD_DATA = 3'd5;
    localparam logic [2:0] c_C_WR      = 3'd6;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_jaddr;
    logic              r_pending;
    logic              r_cmd_wr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mondreg;
    logic              r_overrun;

    logic w_final;
    logic w_can_accept;
    logic w_any_pulse;
    logic w_multi_pulse;
    logic w_accept;
    logic w_drop;
    logic w_load_addr;
    logic w_new_queue;
    logic w_go_dbg;
    logic w_go_wr;
    logic w_unused;

    // The last state of a debug command frees the slot in the same cycle.
    assign w_final       = (r_state == c_J_RD_DATA) || (r_state == c_J_WR);
    assign w_can_accept  = !r_pending || w_final;
    assign w_any_pulse   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_multi_pulse = (take_action_ocimem_a & take_no_action_ocimem_a)
                         | (take_action_ocimem_a & take_action_ocimem_b)
                         | (take_no_action_ocimem_a & take_action_ocimem_b);
    assign w_accept      = w_any_pulse & w_can_accept;
    assign w_drop        = w_any_pulse & (!w_can_accept | w_multi_pulse);
    assign w_load_addr   = w_accept & take_action_ocimem_a & !take_action_ocimem_b;
    // Address-only loads (jdo[35]=0) do not occupy the command slot.
    assign w_new_queue   = w_accept & (take_action_ocimem_b |
                           (take_action_ocimem_a ? jdo[35] : take_no_action_ocimem_a));
    assign w_go_dbg      = w_new_queue | r_pending;
    assign w_go_wr       = w_new_queue ? take_action_ocimem_b : r_cmd_wr;
    assign w_unused      = ^{jdo[37:36], jdo[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE: begin
                if (w_go_dbg) begin
                    w_next_state = w_go_wr ? c_J_WR : c_J_RD;
                end else if (avs_write) begin
                    w_next_state = c_C_WR;
                end else if (avs_read) begin
                    w_next_state = c_C_RD;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            c_J_RD:      w_next_state = c_J_RD_DATA;
            c_J_RD_DATA: w_next_state = c_IDLE;
            c_J_WR:      w_next_state = c_IDLE;
            c_C_RD:      w_next_state = c_C_RD_DATA;
            c_C_RD_DATA: w_next_state = c_IDLE;
            c_C_WR:      w_next_state = c_IDLE;
            default:     w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        ram_addr     = '0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        avs_readdata = '0;
        case (r_state)
            c_J_RD, c_J_RD_DATA: begin
                ram_addr = r_jaddr;
            end
            c_J_WR: begin
                ram_addr  = r_jaddr;
                ram_we    = 1'b1;
                ram_wdata = r_wdata;
            end
            c_C_RD: begin
                ram_addr = avs_address;
            end
            c_C_RD_DATA: begin
                ram_addr     = avs_address;
                avs_readdata = ram_rdata;
            end
            c_C_WR: begin
                ram_addr  = avs_address;
                ram_we    = 1'b1;
                ram_wdata = avs_writedata;
            end
            default: begin
                ram_addr = '0;
            end
        endcase
    end

    assign avs_waitrequest = (avs_read | avs_write) &&
                             !((r_state == c_C_WR) || (r_state == c_C_RD_DATA));

    // An accepted address load overrides the post-access increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jaddr   <= '0;
            r_pending <= 1'b0;
            r_cmd_wr  <= 1'b0;
            r_wdata   <= '0;
            r_mondreg <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load_addr) begin
                r_jaddr <= jdo[ADDR_W+1:2];
            end else if (w_final) begin
                r_jaddr <= r_jaddr + c_ADDR_ONE;
            end

            if (w_new_queue) begin
                r_pending <= 1'b1;
                r_cmd_wr  <= take_action_ocimem_b;
            end else if (w_final) begin
                r_pending <= 1'b0;
            end

            if (w_accept && take_action_ocimem_b) begin
                r_wdata <= jdo[34:3];
            end

            if (r_state == c_J_RD_DATA) begin
                r_mondreg <= ram_rdata;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign MonDReg       = r_mondreg;
    assign monitor_ready = !r_pending;
    assign cmd_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nios2_system_v0_cpu_cpu_debug_ocimem_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_nios2_system_v0_cpu_cpu_debug_ocimem_arb
// Brief   : Randomized self-checking bench with a transaction-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_nios2_system_v0_cpu_cpu_debug_ocimem_arb;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int K_A    = 0;
    localparam int K_NA   = 1;
    localparam int K_B    = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              cmd_overrun;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    nios2_system_v0_cpu_cpu_debug_ocimem_arb #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .cmd_overrun             (cmd_overrun),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_we                  (ram_we),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM attached to the arbiter, preloaded through a side port.
    logic [31:0]       ram [DEPTH];
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [31:0]       init_data;

    always @(posedge clk) begin
        if (init_we) begin
            ram[init_addr] <= init_data;
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_addr];
    end

    // Transaction-level model: golden memory, debug address, sticky flag,
    // last debug read value and the ordered list of expected RAM writes.
    logic [31:0]        gm [DEPTH];
    logic [ADDR_W-1:0]  mj;
    logic               mo;
    logic [31:0]        mmon;
    logic [ADDR_W+31:0] wq [$];
    logic [ADDR_W+31:0] exp_w;
    int                 checks = 0;
    int                 errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_rd(input int k, input logic [37:0] d);
        return (k == K_NA) || (k == K_A && d[35]);
    endfunction

    function automatic int dbg_lat(input int k, input logic [37:0] d);
        if (is_rd(k, d)) return 2;
        if (k == K_B) return 1;
        return 0;
    endfunction

    function automatic logic [37:0] mk_jdo(input int k, input logic [ADDR_W-1:0] a,
                                           input logic rd, input logic [31:0] wd);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (k == K_A) begin
            r[ADDR_W+1:2] = a;
            r[35]         = rd;
        end else if (k == K_B) begin
            r[34:3] = wd;
        end
        return r[37:0];
    endfunction

    function automatic logic [37:0] rnd_jdo(input int k);
        return mk_jdo(k, ADDR_W'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)), $urandom());
    endfunction

    task automatic m_accept(input int k, input logic [37:0] d);
        if (k == K_A) begin
            mj = d[ADDR_W+1:2];
            if (d[35]) begin
                mmon = gm[mj];
                mj   = mj + ADDR_W'(1);
            end
        end else if (k == K_NA) begin
            mmon = gm[mj];
            mj   = mj + ADDR_W'(1);
        end else begin
            gm[mj] = d[34:3];
            wq.push_back({mj, d[34:3]});
            mj = mj + ADDR_W'(1);
        end
    endtask

    task automatic dbg_drive(input int k, input logic [37:0] d);
        jdo                     = d;
        take_action_ocimem_a    = (k == K_A);
        take_no_action_ocimem_a = (k == K_NA);
        take_action_ocimem_b    = (k == K_B);
    endtask

    task automatic dbg_clear();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!monitor_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", 64'(monitor_ready), 64'd1);
    endtask

    task automatic dbg_op(input int k, input logic [37:0] d);
        int n;
        dbg_drive(k, d);
        tick();
        dbg_clear();
        m_accept(k, d);
        wait_ready(n);
        chk("dbg_latency", 64'(n), 64'(dbg_lat(k, d)));
    endtask

    // Second pulse lands 1 or 2 cycles after the first; only a debug read
    // still occupies the slot one cycle later.
    task automatic pair_op(input int k1, input logic [37:0] d1,
                           input int k2, input logic [37:0] d2, input int offset);
        int n;
        dbg_drive(k1, d1);
        tick();
        dbg_clear();
        m_accept(k1, d1);
        if (offset == 2) tick();
        dbg_drive(k2, d2);
        tick();
        dbg_clear();
        if (offset == 1 && is_rd(k1, d1)) mo = 1'b1;
        else m_accept(k2, d2);
        wait_ready(n);
    endtask

    task automatic multi_op(input int combo);
        int          n;
        logic [37:0] d;
        d = rnd_jdo(K_A);
        jdo = d;
        take_action_ocimem_b    = (combo != 2);
        take_action_ocimem_a    = (combo != 1);
        take_no_action_ocimem_a = (combo != 0);
        tick();
        dbg_clear();
        m_accept((combo == 2) ? K_A : K_B, d);
        mo = 1'b1;
        wait_ready(n);
    endtask

    task automatic cpu_op(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                          input bit with_dbg, input int k, input logic [37:0] d,
                          output int lat, output logic [31:0] rd);
        int extra;
        extra = 0;
        if (with_dbg) extra = is_rd(k, d) ? 3 : ((k == K_B) ? 2 : 0);
        avs_address   = a;
        avs_write     = wr;
        avs_read      = !wr;
        avs_writedata = wd;
        if (with_dbg) dbg_drive(k, d);
        lat = -1;
        rd  = '0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            #1;
            if (!avs_waitrequest) begin
                lat = c;
                rd  = avs_readdata;
                if (!wr) chk("cpu_rdata", 64'(avs_readdata), 64'(gm[a]));
            end
            tick();
            if (c == 0) begin
                dbg_clear();
                if (with_dbg) m_accept(k, d);
                if (wr) begin
                    gm[a] = wd;
                    wq.push_back({a, wd});
                end
            end
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        chk("cpu_latency", 64'(lat), 64'((wr ? 1 : 2) + extra));
    endtask

    // Compare process: reset values while reset is held, otherwise the model's
    // sticky flag, debug read data whenever idle, and every RAM write.
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_mondreg", 64'(MonDReg), 64'd0);
            chk("rst_overrun", 64'(cmd_overrun), 64'd0);
            chk("rst_ready", 64'(monitor_ready), 64'd1);
            chk("rst_readdata", 64'(avs_readdata), 64'd0);
            chk("rst_ram_we", 64'(ram_we), 64'd0);
            chk("rst_ram_addr", 64'(ram_addr), 64'd0);
            chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
            if (avs_read || avs_write) chk("rst_waitreq", 64'(avs_waitrequest), 64'd1);
        end else begin
            chk("overrun", 64'(cmd_overrun), 64'(mo));
            if (monitor_ready) chk("mondreg", 64'(MonDReg), 64'(mmon));
            if (ram_we) begin
                chk("write_expected", 64'(wq.size() > 0), 64'd1);
                if (wq.size() > 0) begin
                    exp_w = wq.pop_front();
                    chk("write_addr_data", 64'({ram_addr, ram_wdata}), 64'(exp_w));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n;
        int          op;
        logic [31:0] rd;
        logic [31:0] old;
        logic [ADDR_W-1:0] tgt;

        reset_n = 1'b0;
        jdo = '0;
        dbg_clear();
        avs_address = '0;
        avs_read = 1'b1;
        avs_write = 1'b0;
        avs_writedata = '0;
        init_we = 1'b0;
        init_addr = '0;
        init_data = '0;
        mj = '0;
        mo = 1'b0;
        mmon = '0;
        for (int i = 0; i < DEPTH; i++) gm[i] = $urandom();
        gm[8'h02] = 32'h2222_2222;
        gm[8'h03] = 32'h3333_3333;
        gm[8'h10] = 32'hDEAD_BEEF;
        gm[8'h11] = 32'hCAFE_F00D;
        gm[8'h20] = 32'h2020_2020;

        tick();
        for (int i = 0; i < DEPTH; i++) begin
            init_we   = 1'b1;
            init_addr = ADDR_W'(i);
            init_data = gm[i];
            tick();
        end
        init_we  = 1'b0;
        avs_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        // Read at 0x10 with address load, then sequential read at 0x11.
        dbg_op(K_A, mk_jdo(K_A, 8'h10, 1'b1, 32'h0));
        chk("s1_mondreg", 64'(MonDReg), 64'hDEAD_BEEF);
        dbg_op(K_NA, rnd_jdo(K_NA));
        chk("s1_jaddr_next", 64'(MonDReg), 64'hCAFE_F00D);

        // Write at 0xFF, then the address wraps to 0x00.
        dbg_op(K_A, mk_jdo(K_A, 8'hFF, 1'b0, 32'h0));
        dbg_op(K_B, mk_jdo(K_B, 8'h0, 1'b0, 32'h1234_5678));
        chk("s2_ram_ff", 64'(ram[8'hFF]), 64'h1234_5678);
        dbg_op(K_B, mk_jdo(K_B, 8'h0, 1'b0, 32'hA5A5_A5A5));
        chk("s2_ram_wrap", 64'(ram[8'h00]), 64'hA5A5_A5A5);

        // CPU read and debug write in the same cycle: debug first.
        cpu_op(1'b0, 8'h20, 32'h0, 1'b1, K_B, mk_jdo(K_B, 8'h0, 1'b0, 32'h0BAD_F00D), lat, rd);
        chk("s3_latency", 64'(lat), 64'd4);
        chk("s3_rdata", 64'(rd), 64'h2020_2020);
        chk("s3_dbg_write", 64'(ram[8'h01]), 64'h0BAD_F00D);

        // Second sequential read while the first is in flight is dropped.
        pair_op(K_NA, rnd_jdo(K_NA), K_NA, rnd_jdo(K_NA), 1);
        chk("s4_overrun", 64'(cmd_overrun), 64'd1);
        chk("s4_first_read", 64'(MonDReg), 64'h2222_2222);
        dbg_op(K_NA, rnd_jdo(K_NA));
        chk("s4_single_advance", 64'(MonDReg), 64'h3333_3333);

        // CPU-only latency pins.
        cpu_op(1'b1, 8'h40, 32'h4040_4040, 1'b0, K_A, '0, lat, rd);
        chk("cpu_wr_lat", 64'(lat), 64'd1);
        cpu_op(1'b0, 8'h40, 32'h0, 1'b0, K_A, '0, lat, rd);
        chk("cpu_rd_lat", 64'(lat), 64'd2);
        chk("cpu_rd_data", 64'(rd), 64'h4040_4040);

        for (int it = 0; it < 120; it++) begin
            op = $urandom_range(0, 8);
            case (op)
                0: dbg_op(K_A, rnd_jdo(K_A));
                1: dbg_op(K_NA, rnd_jdo(K_NA));
                2: dbg_op(K_B, rnd_jdo(K_B));
                3: cpu_op(1'b0, ADDR_W'($urandom_range(0, DEPTH - 1)), 32'h0, 1'b0, K_A, '0, lat, rd);
                4: cpu_op(1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom(), 1'b0, K_A, '0, lat, rd);
                5: begin
                    n = $urandom_range(0, 2);
                    cpu_op(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
                           $urandom(), 1'b1, n, rnd_jdo(n), lat, rd);
                end
                6: begin
                    n = $urandom_range(0, 2);
                    op = $urandom_range(0, 2);
                    pair_op(n, rnd_jdo(n), op, rnd_jdo(op), 1);
                end
                7: begin
                    n = $urandom_range(0, 2);
                    op = $urandom_range(0, 2);
                    pair_op(n, rnd_jdo(n), op, rnd_jdo(op), 2);
                end
                default: multi_op($urandom_range(0, 3));
            endcase
        end

        // Reset asserted while the debug write is in J_WR.
        tgt = mj;
        old = gm[tgt];
        dbg_drive(K_B, mk_jdo(K_B, 8'h0, 1'b0, ~old));
        tick();
        dbg_clear();
        #1;
        reset_n  = 1'b0;
        avs_read = 1'b1;
        tick();
        tick();
        avs_read = 1'b0;
        mj   = '0;
        mo   = 1'b0;
        mmon = '0;
        reset_n = 1'b1;
        tick();
        chk("s5_no_write", 64'(ram[tgt]), 64'(old));
        chk("s5_overrun_clear", 64'(cmd_overrun), 64'd0);
        dbg_op(K_NA, rnd_jdo(K_NA));
        chk("s5_next_read", 64'(MonDReg), 64'(gm[0]));

        tick();
        chk("writes_drained", 64'(wq.size()), 64'd0);
        for (int i = 0; i < DEPTH; i++) chk("final_mem", 64'(ram[i]), 64'(gm[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios2_system_v0_cpu_cpu_debug_ocimem_arb.md
NIOS2_SYSTEM_V0_CPU_CPU_DEBUG_OCIMEM_ARB -- requirements
Module: nios2_system_v0_cpu_cpu_debug_ocimem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the word-address width of the shared debug RAM (256 x 32).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset; it is asynchronous and active-low.
REQ-004 SHALL have port jdo, input, 38, the debug command data word.
REQ-005 SHALL have port take_action_ocimem_a, input, 1, a one-cycle pulse that sets the address and optionally reads.
REQ-006 SHALL have port take_no_action_ocimem_a, input, 1, a one-cycle pulse that reads at the current address and then increments it.
REQ-007 SHALL have port take_action_ocimem_b, input, 1, a one-cycle pulse that writes at the current address and then increments it.
REQ-008 SHALL have port MonDReg, output, 32, the last debug read data.
REQ-009 SHALL have port monitor_ready, output, 1, meaning no debug command is pending or in flight.
REQ-010 SHALL have port cmd_overrun, output, 1, a sticky flag meaning a debug command was dropped.
REQ-011 SHALL have port avs_address, input, ADDR_W, the CPU slave word address.
REQ-012 SHALL have port avs_read, input, 1, the CPU slave read request.
REQ-013 SHALL have port avs_write, input, 1, the CPU slave write request.
REQ-014 SHALL have port avs_writedata, input, 32, the CPU slave write data.
REQ-015 SHALL have port avs_readdata, output, 32, the CPU slave read data.
REQ-016 SHALL have port avs_waitrequest, output, 1, the CPU slave stall.
REQ-017 SHALL have port ram_addr, output, ADDR_W, the address to the shared single-port RAM.
REQ-018 SHALL have port ram_we, output, 1, the RAM write enable.
REQ-019 SHALL have port ram_wdata, output, 32, the RAM write data.
REQ-020 SHALL have port ram_rdata, input, 32, the RAM read data, valid 1 cycle after the read address is presented.

Function
REQ-021 SHALL decode debug commands as follows.
- take_action_ocimem_a: load the address register (jaddr) from jdo[ADDR_W+1:2].
- If jdo[35]=1 on take_action_ocimem_a, also queue a read at the new address.
- take_no_action_ocimem_a: queue a read at jaddr.
- take_action_ocimem_b: queue a write of jdo[34:3] at jaddr.
REQ-022 SHALL hold at most one pending debug command.
- A command pulse that arrives while a debug command is pending or in flight is dropped entirely, including its address load.
- A dropped command sets cmd_overrun; cmd_overrun stays set until reset.
REQ-023 SHALL implement the FSM states IDLE, J_RD, J_RD_DATA, J_WR, C_RD, C_RD_DATA and C_WR.
REQ-024 SHALL arbitrate from IDLE in this order.
- A pending debug command wins: go to J_RD or J_WR.
- Otherwise avs_write goes to C_WR.
- Otherwise avs_read goes to C_RD.
- Otherwise stay in IDLE.
REQ-025 SHALL drive ram_addr from jaddr in J_*, and from avs_address in C_*.
REQ-026 SHALL assert ram_we for exactly one cycle, in J_WR or C_WR only.
REQ-027 SHALL handle debug reads as follows.
- J_RD presents the address.
- J_RD_DATA captures ram_rdata into MonDReg and increments jaddr, wrapping mod 2^ADDR_W.
- The FSM then returns to IDLE.
REQ-028 SHALL handle debug writes as follows: J_WR writes, increments jaddr with wrap, clears the pending command, and returns to IDLE.
REQ-029 SHALL hold avs_waitrequest high whenever avs_read or avs_write is asserted, except in the cycles below.
- C_WR: write completes, waitrequest low.
- C_RD_DATA: avs_readdata = ram_rdata, waitrequest low.
REQ-030 SHALL keep CPU latency in the absence of debug traffic to 2 cycles for a read and 1 cycle for a write, measured from request to waitrequest low.
REQ-031 SHALL let a debug command arriving during a CPU access wait until that CPU access completes; a CPU access in flight is never aborted.
REQ-032 SHALL keep monitor_ready = 0 from the cycle after an accepted command pulse until the cycle after that command's final state.
REQ-033 SHALL treat a command pulse that arrives in the same cycle the FSM leaves J_RD_DATA or J_WR as accepted, not dropped.
REQ-034 SHALL give priority to take_action_ocimem_b, then take_action_ocimem_a, then take_no_action_ocimem_a if more than one pulse arrives in the same cycle; the others are dropped and set cmd_overrun.

Reset
REQ-035 SHALL, while reset_n = 0, force the following asynchronously.
- FSM = IDLE, jaddr = 0, no command pending.
- MonDReg = 0, cmd_overrun = 0, monitor_ready = 1.
- avs_readdata = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0.
- avs_waitrequest = 1 whenever avs_read or avs_write is asserted.
REQ-036 SHALL discard any in-flight access, with no RAM write, if reset is asserted mid-operation.

Verification
REQ-037 SHALL be verified by scenario 1: take_action_ocimem_a with jdo[ADDR_W+1:2]=0x10, jdo[35]=1, and RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF, jaddr=0x11, monitor_ready high again 3 cycles after the pulse.
REQ-038 SHALL be verified by scenario 2: jaddr=0xFF, then take_action_ocimem_b with data 0x12345678 -> RAM[0xFF]=0x12345678 and jaddr wraps to 0x00.
REQ-039 SHALL be verified by scenario 3: avs_read at 0x20 and a debug write pulse in the same cycle -> debug write first, CPU read completes 2 cycles later, avs_waitrequest high throughout.
REQ-040 SHALL be verified by scenario 4: a second take_no_action_ocimem_a while the first is pending -> only one read, jaddr advances by 1, cmd_overrun=1 until reset.
REQ-041 SHALL be verified by scenario 5: reset_n pulsed low during J_WR -> no RAM write, all outputs at their REQ-035 values, and the next command behaves normally.
